maria_video_out: RTL and testbench

Pixel back end downstream of the Maria video core. Samples Maria's 8-bit YC pixel and sync/blank flags on each pixel strobe, converts YC to 24-bit RGB through a loadable two-bank palette RAM (NTSC/PAL), and delays the sync and blank flags to match. It also provides a pixel clock-enable, a line counter and a per-frame line total for the scaler and OSD.

---
 rtl/maria_video_out.sv | 139 +++++++++++++
 tb/tb_maria_video_out.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maria_video_out.sv
// maria_video_out
// Pixel back end for the Maria video core. Each pixel strobe samples Maria's
// YC pixel and timing flags, looks the pixel up in a loadable two-bank
// palette RAM and presents 24-bit RGB one strobe later. Sync and blank flags
// are delayed by the same amount. A line counter, a per-frame line total and
// a field toggle are maintained for the scaler and OSD.
//
// Ports:
//   clk_sys          system clock (only clock)
//   reset_n          asynchronous active-low reset
//   mclk0            Maria pixel strobe, one clk_sys wide, >=2 cycles apart
//   PAL              palette bank request, latched at vsync rise
//   YC               pixel: [7:4] hue, [3:0] luma
//   hsync/vsync      Maria sync flags
//   hblank/vblank    Maria blank flags
//   pal_wr           palette write strobe
//   pal_addr         palette write address {bank, YC}
//   pal_data         palette write data {R,G,B}
//   R/G/B            pixel colour
//   hs_out/vs_out    delayed sync flags
//   hbl_out/vbl_out  delayed blank flags
//   ce_pix           pulses the cycle after an output update
//   line_count       current line in frame (saturating)
//   lines_per_frame  line total of the last completed frame
//   field            toggles every frame

module maria_video_out #(
  parameter int LINE_W = 9
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              mclk0,
  input  logic              PAL,
  input  logic [7:0]        YC,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              pal_wr,
  input  logic [8:0]        pal_addr,
  input  logic [23:0]       pal_data,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              hs_out,
  output logic              vs_out,
  output logic              hbl_out,
  output logic              vbl_out,
  output logic              ce_pix,
  output logic [LINE_W-1:0] line_count,
  output logic [LINE_W-1:0] lines_per_frame,
  output logic              field
);

  logic [23:0] pal_mem [0:511];
  logic [23:0] ram_q;

  logic [7:0]  s1_yc;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_hb;
  logic        s1_vb;
  logic        bank;

  logic [8:0]  rd_addr;
  logic        hs_rise;
  logic        vs_rise;
  logic        s1_blank;

  // Edges compare the sample being captured now against the previous
  // stage-1 sample, so they only exist on strobe cycles.
  assign hs_rise  = mclk0 & hsync & ~s1_hs;
  assign vs_rise  = mclk0 & vsync & ~s1_vs;
  assign rd_addr  = {bank, s1_yc};
  assign s1_blank = s1_hb | s1_vb;

  // Palette RAM: not reset so contents survive reset_n. The read sees the
  // pre-write contents on a same-address collision. Strobes are at least two
  // cycles apart, so ram_q has settled on the stage-1 address by stage 2.
  always_ff @(posedge clk_sys) begin
    if (pal_wr) begin
      pal_mem[pal_addr] <= pal_data;
    end
    ram_q <= pal_mem[rd_addr];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      R               <= '0;
      G               <= '0;
      B               <= '0;
      hs_out          <= 1'b0;
      vs_out          <= 1'b0;
      hbl_out         <= 1'b0;
      vbl_out         <= 1'b0;
      ce_pix          <= 1'b0;
      line_count      <= '0;
      lines_per_frame <= '0;
      field           <= 1'b0;
      s1_yc           <= '0;
      s1_hs           <= 1'b0;
      s1_vs           <= 1'b0;
      s1_hb           <= 1'b0;
      s1_vb           <= 1'b0;
      bank            <= 1'b0;
    end else begin
      ce_pix <= mclk0;
      if (mclk0) begin
        // Stage 2: present the pixel captured on the previous strobe.
        R       <= s1_blank ? 8'h00 : ram_q[23:16];
        G       <= s1_blank ? 8'h00 : ram_q[15:8];
        B       <= s1_blank ? 8'h00 : ram_q[7:0];
        hs_out  <= s1_hs;
        vs_out  <= s1_vs;
        hbl_out <= s1_hb;
        vbl_out <= s1_vb;

        // Stage 1: sample Maria.
        s1_yc <= YC;
        s1_hs <= hsync;
        s1_vs <= vsync;
        s1_hb <= hblank;
        s1_vb <= vblank;

        // vsync takes priority over a coincident hsync edge. The bank only
        // changes here so a frame never mixes palettes.
        if (vs_rise) begin
          lines_per_frame <= line_count;
          line_count      <= '0;
          field           <= ~field;
          bank            <= PAL;
        end else if (hs_rise && (line_count != {LINE_W{1'b1}})) begin
          line_count <= line_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maria_video_out.sv
// tb_maria_video_out
// Directed, table-driven bench for maria_video_out: palette readback,
// blanking, bank switching at vsync, line counting and saturation,
// coincident hsync/vsync, and asynchronous reset with palette retention.

module tb_maria_video_out;

  localparam int LINE_W = 9;

  logic              clk_sys;
  logic              reset_n;
  logic              mclk0;
  logic              PAL;
  logic [7:0]        YC;
  logic              hsync;
  logic              vsync;
  logic              hblank;
  logic              vblank;
  logic              pal_wr;
  logic [8:0]        pal_addr;
  logic [23:0]       pal_data;
  logic [7:0]        R;
  logic [7:0]        G;
  logic [7:0]        B;
  logic              hs_out;
  logic              vs_out;
  logic              hbl_out;
  logic              vbl_out;
  logic              ce_pix;
  logic [LINE_W-1:0] line_count;
  logic [LINE_W-1:0] lines_per_frame;
  logic              field;

  int errors = 0;
  int checks = 0;

  maria_video_out #(.LINE_W(LINE_W)) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .mclk0           (mclk0),
    .PAL             (PAL),
    .YC              (YC),
    .hsync           (hsync),
    .vsync           (vsync),
    .hblank          (hblank),
    .vblank          (vblank),
    .pal_wr          (pal_wr),
    .pal_addr        (pal_addr),
    .pal_data        (pal_data),
    .R               (R),
    .G               (G),
    .B               (B),
    .hs_out          (hs_out),
    .vs_out          (vs_out),
    .hbl_out         (hbl_out),
    .vbl_out         (vbl_out),
    .ce_pix          (ce_pix),
    .line_count      (line_count),
    .lines_per_frame (lines_per_frame),
    .field           (field)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        pal;
    logic [7:0]  yc;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [23:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_hb;
    logic        exp_vb;
  } vec_t;

  vec_t vecs [13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pal_write(input logic [8:0] addr, input logic [23:0] data);
    @(negedge clk_sys);
    pal_wr   = 1'b1;
    pal_addr = addr;
    pal_data = data;
    @(negedge clk_sys);
    pal_wr   = 1'b0;
  endtask

  // One strobe: inputs set on a falling edge, sampled on the next rising
  // edge. Returns on the falling edge right after, when ce_pix is high.
  task automatic apply_stimulus(input logic pal, input logic [7:0] yc, input logic hs,
                                input logic vs, input logic hb, input logic vb);
    @(negedge clk_sys);
    PAL    = pal;
    YC     = yc;
    hsync  = hs;
    vsync  = vs;
    hblank = hb;
    vblank = vb;
    mclk0  = 1'b1;
    @(negedge clk_sys);
    mclk0  = 1'b0;
  endtask

  // Strobe plus one idle cycle to keep strobes two cycles apart.
  task automatic strobe(input logic pal, input logic [7:0] yc, input logic hs,
                        input logic vs, input logic hb, input logic vb);
    apply_stimulus(pal, yc, hs, vs, hb, vb);
    @(negedge clk_sys);
  endtask

  task automatic hsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(1'b0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0);
      strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " rgb"},   {8'h0, R, G, B}, 32'h0);
    check_output({tag, " flags"}, {28'h0, hs_out, vs_out, hbl_out, vbl_out}, 32'h0);
    check_output({tag, " ce_pix"}, {31'h0, ce_pix}, 32'h0);
    check_output({tag, " line_count"}, {23'h0, line_count}, 32'h0);
    check_output({tag, " lines_per_frame"}, {23'h0, lines_per_frame}, 32'h0);
    check_output({tag, " field"}, {31'h0, field}, 32'h0);
  endtask

  initial begin
    reset_n  = 1'b1;
    mclk0    = 1'b0;
    PAL      = 1'b0;
    YC       = 8'h00;
    hsync    = 1'b0;
    vsync    = 1'b0;
    hblank   = 1'b0;
    vblank   = 1'b0;
    pal_wr   = 1'b0;
    pal_addr = '0;
    pal_data = '0;

    //          pal   yc     hs    vs    hb    vb    exp_rgb     ehs   evs   ehb   evb
    vecs[0]  = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b1, 1'b0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0};

    #3 reset_n = 1'b0;
    #2 check_all_zero("initial reset");
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;

    pal_write(9'h000, 24'h000000);
    pal_write(9'h100, 24'h000000);
    pal_write(9'h03A, 24'h123456);
    pal_write(9'h005, 24'h0A0B0C);
    pal_write(9'h13A, 24'hABCDEF);

    check_output("ce_pix idle", {31'h0, ce_pix}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].pal, vecs[i].yc, vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb);
      check_output($sformatf("vec%0d rgb", i), {8'h0, R, G, B}, {8'h0, vecs[i].exp_rgb});
      check_output($sformatf("vec%0d flags", i), {28'h0, hs_out, vs_out, hbl_out, vbl_out},
                   {28'h0, vecs[i].exp_hs, vecs[i].exp_vs, vecs[i].exp_hb, vecs[i].exp_vb});
      check_output($sformatf("vec%0d ce_pix high", i), {31'h0, ce_pix}, 32'h1);
      @(negedge clk_sys);
      check_output($sformatf("vec%0d ce_pix low", i), {31'h0, ce_pix}, 32'h0);
      check_output($sformatf("vec%0d rgb hold", i), {8'h0, R, G, B}, {8'h0, vecs[i].exp_rgb});
    end

    // One hsync rise (vec6) then a vsync rise (vec9) in the table.
    check_output("table lines_per_frame", {23'h0, lines_per_frame}, 32'd1);
    check_output("table line_count", {23'h0, line_count}, 32'd0);
    check_output("table field", {31'h0, field}, 32'h1);

    // 263 lines between vsync rises.
    strobe(1'b0, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("frame start field", {31'h0, field}, 32'h0);
    hsync_pulses(263);
    check_output("263 line_count", {23'h0, line_count}, 32'd263);
    strobe(1'b0, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("263 lines_per_frame", {23'h0, lines_per_frame}, 32'd263);
    check_output("263 line_count cleared", {23'h0, line_count}, 32'd0);
    check_output("263 field toggled", {31'h0, field}, 32'h1);
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation.
    hsync_pulses(600);
    check_output("saturate line_count", {23'h0, line_count}, 32'd511);
    strobe(1'b0, 8'h3A, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("saturate lines_per_frame", {23'h0, lines_per_frame}, 32'd511);
    check_output("saturate field", {31'h0, field}, 32'h0);
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Coincident hsync and vsync rise: vsync wins.
    hsync_pulses(5);
    check_output("pre-coincident line_count", {23'h0, line_count}, 32'd5);
    strobe(1'b0, 8'h3A, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("coincident line_count", {23'h0, line_count}, 32'd0);
    check_output("coincident lines_per_frame", {23'h0, lines_per_frame}, 32'd5);
    check_output("coincident field", {31'h0, field}, 32'h1);
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("post-coincident line_count", {23'h0, line_count}, 32'd0);

    // No strobes: outputs hold.
    hsync = 1'b1;
    repeat (4) @(negedge clk_sys);
    hsync = 1'b0;
    check_output("no strobe hold line_count", {23'h0, line_count}, 32'd0);

    // Asynchronous reset between strobes; palette survives.
    hsync_pulses(3);
    check_output("pre-reset line_count", {23'h0, line_count}, 32'd3);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk_sys);
    reset_n = 1'b1;
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("reset first strobe rgb", {8'h0, R, G, B}, 32'h0);
    strobe(1'b0, 8'h3A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("reset readback rgb", {8'h0, R, G, B}, 32'h00123456);
    check_output("reset readback field", {31'h0, field}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
